// File: rtl/load_unit.sv
// Load unit: fetches one or two aligned words from data memory, merges them and
// returns the addressed byte/halfword/word sign- or zero-extended.
module load_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  output logic        o_busy,
  output logic        o_mem_rd,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_valid,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_err
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD1  = 2'd1,
    S_RD2  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_two;
  logic [31:0] r_addr;
  logic [31:0] r_w1;
  logic [31:0] r_data;
  logic        r_err;

  logic        w_legal;
  logic        w_two;
  logic        w_last;
  logic [31:0] w_lo;
  logic [23:0] w_hi;
  logic [55:0] w_pair;
  logic [31:0] w_r;
  logic [31:0] w_ext;

  always_comb begin
    w_legal = 1'b0;
    case (i_funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: w_legal = 1'b1;
      default:                             w_legal = 1'b0;
    endcase
  end

  assign w_two = (((i_funct3 == F3_LH) || (i_funct3 == F3_LHU)) && (i_addr[1:0] == 2'd3)) ||
                 ((i_funct3 == F3_LW) && (i_addr[1:0] != 2'd0));

  // Final access of the load completes this cycle; result is registered on this edge.
  assign w_last = ((r_state == S_RD1) && i_mem_valid && !r_two) ||
                  ((r_state == S_RD2) && i_mem_valid);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_req) w_state_nxt = w_legal ? S_RD1 : S_DONE;
      S_RD1:  if (i_mem_valid) w_state_nxt = r_two ? S_RD2 : S_DONE;
      S_RD2:  if (i_mem_valid) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Only the low 24 bits of the second word can ever reach the result (max offset 3).
  assign w_lo   = (r_state == S_RD1) ? i_mem_data : r_w1;
  assign w_hi   = (r_state == S_RD2) ? i_mem_data[23:0] : 24'h0;
  assign w_pair = {w_hi, w_lo};

  always_comb begin
    w_r = w_pair[31:0];
    case (r_off)
      2'd0: w_r = w_pair[31:0];
      2'd1: w_r = w_pair[39:8];
      2'd2: w_r = w_pair[47:16];
      2'd3: w_r = w_pair[55:24];
      default: w_r = w_pair[31:0];
    endcase
  end

  always_comb begin
    w_ext = w_r;
    case (r_f3)
      F3_LB:   w_ext = {{24{w_r[7]}}, w_r[7:0]};
      F3_LBU:  w_ext = {24'h0, w_r[7:0]};
      F3_LH:   w_ext = {{16{w_r[15]}}, w_r[15:0]};
      F3_LHU:  w_ext = {16'h0, w_r[15:0]};
      default: w_ext = w_r;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_f3    <= 3'b000;
      r_off   <= 2'b00;
      r_two   <= 1'b0;
      r_addr  <= 32'h0;
      r_w1    <= 32'h0;
      r_data  <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_f3  <= i_funct3;
            r_off <= i_addr[1:0];
            r_two <= w_two;
            if (w_legal) begin
              r_addr <= {i_addr[31:2], 2'b00};
            end else begin
              r_err  <= 1'b1;
              r_data <= 32'h0;
            end
          end
        end
        S_RD1: begin
          if (i_mem_valid) begin
            r_w1 <= i_mem_data;
            if (r_two) r_addr <= r_addr + 32'd4;
          end
        end
        S_DONE: r_err <= 1'b0;
        default: ;
      endcase
      if (w_last) r_data <= w_ext;
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_mem_rd   = (r_state == S_RD1) || (r_state == S_RD2);
  assign o_mem_addr = r_addr;
  assign o_valid    = (r_state == S_DONE);
  assign o_data     = r_data;
  assign o_err      = r_err;

endmodule

// File: doc/load_unit.md
# load_unit

Load-side counterpart of the data-memory store path: accepts a load request (funct3, byte address) from the execute stage and fetches one or two aligned 32-bit words from data memory over a valid/ready-style read handshake. It merges the words, extracts the addressed byte/halfword/word, and returns it sign- or zero-extended to the writeback stage. Misaligned LH/LHU/LW that cross a word boundary are split into two sequential word reads.

## Interface
Parameters: none.
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req  in  1  load request; accepted only in IDLE
- i_funct3  in  3  RV32I load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- i_addr  in  32  byte address of load
- o_busy  out  1  high whenever FSM not in IDLE
- o_mem_rd  out  1  memory read strobe, held until accepted
- o_mem_addr  out  32  word-aligned read address (bits [1:0] = 00)
- i_mem_data  in  32  read data, valid when i_mem_valid high
- i_mem_valid  in  1  read response; completes access when o_mem_rd high same cycle
- o_valid  out  1  one-cycle result strobe
- o_data  out  32  extended load result; holds until next result
- o_err  out  1  illegal funct3, pulses with o_valid

## Operation
- States: IDLE, RD1, RD2, DONE.
- IDLE: on i_req=1, latch funct3, addr[1:0], base = {addr[31:2],2'b00}; compute two_word = (LH/LHU & off==3) | (LW & off!=0).
  - Legal funct3 -> RD1. Illegal -> DONE with o_err=1, o_data=0, no memory access.
- RD1: o_mem_rd=1, o_mem_addr=base. On i_mem_valid: capture w1; -> RD2 if two_word else DONE.
- RD2: o_mem_rd=1, o_mem_addr=base+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000). On i_mem_valid: capture w2 -> DONE.
- DONE: o_valid=1 for exactly this cycle, o_data/o_err registered; -> IDLE.
- Extraction: r = ({w2,w1} >> (8*off))[31:0]; w2 treated as 0 when single-word.
  - LB: {{24{r[7]}},r[7:0]}; LBU: {24'b0,r[7:0]}.
  - LH: {{16{r[15]}},r[15:0]}; LHU: {16'b0,r[15:0]}; LW: r.
- i_req outside IDLE ignored (not queued). i_mem_valid without o_mem_rd ignored.
- o_mem_addr and o_mem_rd stable while waiting for i_mem_valid.

## Timing
- Reset values: state IDLE, o_busy 0, o_mem_rd 0, o_mem_addr 0, o_valid 0, o_data 0, o_err 0.
- Request at edge k (IDLE): o_mem_rd high cycle k+1.
- Zero-wait memory (i_mem_valid same cycle as o_mem_rd): single-word o_valid at k+2; two-word RD2 at k+2, o_valid at k+3.
- Each wait cycle of i_mem_valid adds one cycle per access.
- Illegal funct3: o_valid/o_err at k+1.
- Earliest next acceptance: cycle after DONE.
- i_rst high at any edge, including mid-RD1/RD2 with pending read: all outputs to reset values next cycle, partial result discarded, no o_valid.

## Test plan
Memory: [0x100]=0xC3B2_A190, [0x104]=0x7766_5544, [0x0]=0x0000_BEEF, [0xFFFF_FFFC]=0x1234_5678; zero-wait unless stated.
- LB/LBU @0x101 -> one read at 0x100; o_data 0xFFFF_FFA1 / 0x0000_00A1; o_valid 2 cycles after request.
- LH @0x102 -> 0xFFFF_C3B2; LHU @0x103 -> reads 0x100 then 0x104, 0x0000_44C3, o_valid at +3.
- LW @0x101 -> 0x44C3_B2A1; LW @0xFFFF_FFFE -> reads 0xFFFF_FFFC then 0x0000_0000, result 0xBEEF_1234.
- LW @0x100 with i_mem_valid delayed 3 cycles -> o_mem_addr 0x100 held, o_mem_rd held, o_data 0xC3B2_A190 at +5.
- funct3=011 -> o_err=1, o_valid=1 at +1, o_data 0, o_mem_rd never asserted; i_req during busy ignored.
- i_rst during RD2 of LW @0x103 -> no o_valid, outputs zero; following LB @0x100 returns 0xFFFF_FF90.
